// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store controller: access sizes, FSM states and
// the default data memory size.
package lsu_pkg;

   localparam int MEM_BYTES_DEF = 128;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RD   = 2'b01,
      ST_WR   = 2'b10,
      ST_DONE = 2'b11
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane handling: extracts and extends sub-word loads, and merges
// sub-word store data into an existing memory word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_addr_lo,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [31:0] i_old_word,
   input  logic [31:0] i_data,
   output logic [31:0] o_load,
   output logic [31:0] o_merged
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [4:0]  w_shift;
   logic [31:0] w_mask;
   logic [31:0] w_lane_data;

   always_comb begin
      w_byte = i_word[7:0];
      case (i_addr_lo)
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         2'd3:    w_byte = i_word[31:24];
         default: w_byte = i_word[7:0];
      endcase
      w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

      o_load = i_word;
      case (i_size)
         SZ_BYTE: o_load = {{24{i_signed & w_byte[7]}}, w_byte};
         SZ_HALF: o_load = {{16{i_signed & w_half[15]}}, w_half};
         default: o_load = i_word;
      endcase
   end

   // Store merge: clear the target lane in the old word, then OR in the new data.
   always_comb begin
      w_shift     = 5'd0;
      w_mask      = 32'hFFFF_FFFF;
      w_lane_data = i_data;
      o_merged    = i_data;
      case (i_size)
         SZ_BYTE: begin
            w_shift     = {i_addr_lo, 3'b000};
            w_mask      = 32'h0000_00FF << w_shift;
            w_lane_data = {24'd0, i_data[7:0]} << w_shift;
            o_merged    = (i_old_word & ~w_mask) | w_lane_data;
         end
         SZ_HALF: begin
            w_shift     = {i_addr_lo[1], 4'b0000};
            w_mask      = 32'h0000_FFFF << w_shift;
            w_lane_data = {16'd0, i_data[15:0]} << w_shift;
            o_merged    = (i_old_word & ~w_mask) | w_lane_data;
         end
         default: o_merged = i_data;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: turns byte/half/word pipeline accesses into aligned
// word accesses, with read-modify-write for sub-word stores.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        isStore,
   input  logic [1:0]  size,
   input  logic        signedLoad,
   input  logic [31:0] addr,
   input  logic [31:0] storeData,
   output logic [31:0] loadData,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [31:0] memAddr,
   output logic [31:0] memWriteData,
   output logic        writeMem,
   input  logic [31:0] memData,
   output lsu_state_t  o_dbg_state
);

   lsu_state_t  r_state;
   lsu_state_t  w_next;
   logic [31:0] r_rq_addr;
   logic [1:0]  r_rq_size;
   logic        r_rq_store;
   logic        r_rq_signed;
   logic [31:0] r_rq_data;
   logic [31:0] r_wbuf;
   logic [31:0] r_load_data;
   logic        r_fault;

   logic        w_accept;
   logic        w_fault;
   logic [32:0] w_last_byte;
   logic [31:0] w_load;
   logic [31:0] w_merged;

   assign w_accept    = (r_state == ST_IDLE) && req;
   // 33-bit sum so an address near 2^32 cannot wrap back into range.
   assign w_last_byte = {1'b0, addr} + 33'd3;
   assign w_fault     = (size == 2'b11)
                      || ((size == SZ_HALF) && addr[0])
                      || ((size == SZ_WORD) && (addr[1:0] != 2'b00))
                      || (w_last_byte >= 33'(MEM_BYTES));

   lsu_align u_align (
      .i_word     (memData),
      .i_addr_lo  (r_rq_addr[1:0]),
      .i_size     (r_rq_size),
      .i_signed   (r_rq_signed),
      .i_old_word (r_wbuf),
      .i_data     (r_rq_data),
      .o_load     (w_load),
      .o_merged   (w_merged)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req) begin
               if (w_fault)                             w_next = ST_DONE;
               else if (isStore && (size == SZ_WORD))   w_next = ST_WR;
               else                                     w_next = ST_RD;
            end
         end
         ST_RD:   w_next = r_rq_store ? ST_WR : ST_DONE;
         ST_WR:   w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_rq_addr   <= 32'd0;
         r_rq_size   <= 2'd0;
         r_rq_store  <= 1'b0;
         r_rq_signed <= 1'b0;
         r_rq_data   <= 32'd0;
         r_wbuf      <= 32'd0;
         r_load_data <= 32'd0;
         r_fault     <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_rq_addr   <= addr;
            r_rq_size   <= size;
            r_rq_store  <= isStore;
            r_rq_signed <= signedLoad;
            r_rq_data   <= storeData;
            r_fault     <= w_fault;
         end else if (r_state == ST_DONE) begin
            r_fault <= 1'b0;
         end
         if (r_state == ST_RD) begin
            if (r_rq_store) r_wbuf      <= memData;
            else            r_load_data <= w_load;
         end
      end
   end

   assign loadData     = r_load_data;
   assign busy         = (r_state != ST_IDLE);
   assign done         = (r_state == ST_DONE);
   assign fault        = r_fault;
   assign writeMem     = (r_state == ST_WR);
   assign memAddr      = {r_rq_addr[31:2], 2'b00};
   assign memWriteData = w_merged;
   assign o_dbg_state  = r_state;

endmodule
